// File: rtl/game_controller.sv
// rtl/game_controller.sv - tic-tac-toe engine: board, turn, win/draw detection, BCD scores
module game_controller #(
    parameter logic [3:0] SCORE_MAX    = 4'd9,
    parameter logic       FIRST_PLAYER = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_valid,
    input  logic [3:0] i_key_code,
    input  logic       i_new_game,
    output logic [8:0] o_x,
    output logic [8:0] o_o,
    output logic       o_turn,
    output logic       o_game_over,
    output logic [1:0] o_winner,
    output logic [7:0] o_win_lines,
    output logic [3:0] o_score_x,
    output logic [3:0] o_score_o,
    output logic       o_move_err
);

    typedef enum logic [2:0] {
        S_PLAY  = 3'd0,
        S_CHECK = 3'd1,
        S_XWIN  = 3'd2,
        S_OWIN  = 3'd3,
        S_DRAW  = 3'd4
    } state_t;

    state_t     r_state;
    logic [8:0] r_x;
    logic [8:0] r_o;
    logic       r_turn;
    logic       r_mover;
    logic       r_next_first;
    logic [1:0] r_winner;
    logic [7:0] r_win_lines;
    logic [3:0] r_score_x;
    logic [3:0] r_score_o;
    logic       r_move_err;
    logic       r_game_over;

    state_t     w_state_nxt;
    logic [8:0] w_x_nxt;
    logic [8:0] w_o_nxt;
    logic       w_turn_nxt;
    logic       w_mover_nxt;
    logic       w_next_first_nxt;
    logic [1:0] w_winner_nxt;
    logic [7:0] w_win_lines_nxt;
    logic [3:0] w_score_x_nxt;
    logic [3:0] w_score_o_nxt;
    logic       w_move_err_nxt;
    logic       w_game_over_nxt;

    logic       w_code_ok;
    logic [3:0] w_cell;
    logic [8:0] w_cell_mask;
    logic       w_cell_free;
    logic [8:0] w_mover_board;
    logic [7:0] w_lines;

    // All eight three-in-a-row patterns of one player's board.
    function automatic logic [7:0] f_lines(input logic [8:0] b);
        logic [7:0] l;
        l[0] = b[0] & b[1] & b[2];
        l[1] = b[3] & b[4] & b[5];
        l[2] = b[6] & b[7] & b[8];
        l[3] = b[0] & b[3] & b[6];
        l[4] = b[1] & b[4] & b[7];
        l[5] = b[2] & b[5] & b[8];
        l[6] = b[0] & b[4] & b[8];
        l[7] = b[2] & b[4] & b[6];
        return l;
    endfunction

    assign w_code_ok     = (i_key_code != 4'd0) && (i_key_code <= 4'd9);
    assign w_cell        = i_key_code - 4'd1;
    assign w_cell_mask   = w_code_ok ? (9'd1 << w_cell) : 9'd0;
    assign w_cell_free   = w_code_ok && (((r_x | r_o) & w_cell_mask) == 9'd0);
    assign w_mover_board = r_mover ? r_o : r_x;
    assign w_lines       = f_lines(w_mover_board);

    // State and registered outputs; reset clears everything including scores.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_PLAY;
            r_x          <= 9'd0;
            r_o          <= 9'd0;
            r_turn       <= FIRST_PLAYER;
            r_mover      <= FIRST_PLAYER;
            r_next_first <= ~FIRST_PLAYER;
            r_winner     <= 2'b00;
            r_win_lines  <= 8'd0;
            r_score_x    <= 4'd0;
            r_score_o    <= 4'd0;
            r_move_err   <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_o          <= w_o_nxt;
            r_turn       <= w_turn_nxt;
            r_mover      <= w_mover_nxt;
            r_next_first <= w_next_first_nxt;
            r_winner     <= w_winner_nxt;
            r_win_lines  <= w_win_lines_nxt;
            r_score_x    <= w_score_x_nxt;
            r_score_o    <= w_score_o_nxt;
            r_move_err   <= w_move_err_nxt;
            r_game_over  <= w_game_over_nxt;
        end
    end

    // Next-state logic; new_game overrides any move and discards a pending CHECK result.
    always_comb begin
        w_state_nxt      = r_state;
        w_x_nxt          = r_x;
        w_o_nxt          = r_o;
        w_turn_nxt       = r_turn;
        w_mover_nxt      = r_mover;
        w_next_first_nxt = r_next_first;
        w_winner_nxt     = r_winner;
        w_win_lines_nxt  = r_win_lines;
        w_score_x_nxt    = r_score_x;
        w_score_o_nxt    = r_score_o;
        w_move_err_nxt   = 1'b0;

        if (i_new_game) begin
            w_state_nxt      = S_PLAY;
            w_x_nxt          = 9'd0;
            w_o_nxt          = 9'd0;
            w_winner_nxt     = 2'b00;
            w_win_lines_nxt  = 8'd0;
            w_turn_nxt       = r_next_first;
            w_next_first_nxt = ~r_next_first;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (i_key_valid) begin
                        if (w_cell_free) begin
                            if (r_turn) w_o_nxt = r_o | w_cell_mask;
                            else        w_x_nxt = r_x | w_cell_mask;
                            w_mover_nxt = r_turn;
                            w_state_nxt = S_CHECK;
                        end else begin
                            w_move_err_nxt = 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    // A completed line wins even when the board is also full.
                    if (w_lines != 8'd0) begin
                        w_win_lines_nxt = w_lines;
                        if (r_mover) begin
                            w_winner_nxt = 2'b10;
                            w_state_nxt  = S_OWIN;
                            if (r_score_o < SCORE_MAX) w_score_o_nxt = r_score_o + 4'd1;
                        end else begin
                            w_winner_nxt = 2'b01;
                            w_state_nxt  = S_XWIN;
                            if (r_score_x < SCORE_MAX) w_score_x_nxt = r_score_x + 4'd1;
                        end
                    end else if ((r_x | r_o) == 9'h1FF) begin
                        w_winner_nxt = 2'b11;
                        w_state_nxt  = S_DRAW;
                    end else begin
                        w_turn_nxt  = ~r_mover;
                        w_state_nxt = S_PLAY;
                    end
                end
                S_XWIN, S_OWIN, S_DRAW: begin
                    if (i_key_valid) w_move_err_nxt = 1'b1;
                end
                default: w_state_nxt = S_PLAY;
            endcase
        end

        w_game_over_nxt = (w_state_nxt == S_XWIN) || (w_state_nxt == S_OWIN) ||
                          (w_state_nxt == S_DRAW);
    end

    assign o_x         = r_x;
    assign o_o         = r_o;
    assign o_turn      = r_turn;
    assign o_game_over = r_game_over;
    assign o_winner    = r_winner;
    assign o_win_lines = r_win_lines;
    assign o_score_x   = r_score_x;
    assign o_score_o   = r_score_o;
    assign o_move_err  = r_move_err;

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - directed table-driven bench for game_controller
module tb_game_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       new_game = 1'b0;
    logic [8:0] x, o;
    logic       turn, game_over, move_err;
    logic [1:0] winner;
    logic [7:0] win_lines;
    logic [3:0] score_x, score_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_controller dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_key_valid (key_valid),
        .i_key_code  (key_code),
        .i_new_game  (new_game),
        .o_x         (x),
        .o_o         (o),
        .o_turn      (turn),
        .o_game_over (game_over),
        .o_winner    (winner),
        .o_win_lines (win_lines),
        .o_score_x   (score_x),
        .o_score_o   (score_o),
        .o_move_err  (move_err)
    );

    // expected = {x, o, turn, winner, win_lines, score_x, score_o, move_err, game_over}
    typedef struct {
        logic        kv;
        logic [3:0]  kc;
        logic        ng;
        logic        rs;
        logic [38:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [38:0] mk(logic [8:0] ex, logic [8:0] eo, logic et, logic [1:0] ew,
                                       logic [7:0] el, logic [3:0] sx, logic [3:0] so,
                                       logic me, logic go);
        return {ex, eo, et, ew, el, sx, so, me, go};
    endfunction

    function automatic logic [38:0] outs();
        return {x, o, turn, winner, win_lines, score_x, score_o, move_err, game_over};
    endfunction

    task automatic add(logic kv, logic [3:0] kc, logic ng, logic rs, logic [8:0] ex,
                       logic [8:0] eo, logic et, logic [1:0] ew, logic [7:0] el,
                       logic [3:0] sx, logic [3:0] so, logic me, logic go);
        vec_t v;
        v.kv = kv; v.kc = kc; v.ng = ng; v.rs = rs;
        v.exp = mk(ex, eo, et, ew, el, sx, so, me, go);
        vecs.push_back(v);
    endtask

    task automatic step(logic kv, logic [3:0] kc, logic ng, logic rs);
        @(negedge clk);
        key_valid = kv; key_code = kc; new_game = ng; rst = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [38:0] act, logic [38:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got x=%h o=%h turn=%b win=%b lines=%h sx=%h so=%h err=%b over=%b, expected x=%h o=%h turn=%b win=%b lines=%h sx=%h so=%h err=%b over=%b",
                     name, act[38:30], act[29:21], act[20], act[19:18], act[17:10], act[9:6],
                     act[5:2], act[1], act[0], exp[38:30], exp[29:21], exp[20], exp[19:18],
                     exp[17:10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic chk4(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // X wins row 0; when O moves first O takes cells 6,7,3 which complete nothing.
    task automatic x_win_game(logic o_first);
        logic [3:0] seq[6];
        int n;
        if (o_first) begin
            seq[0] = 4'd7; seq[1] = 4'd1; seq[2] = 4'd8; seq[3] = 4'd2; seq[4] = 4'd4; seq[5] = 4'd3; n = 6;
        end else begin
            seq[0] = 4'd1; seq[1] = 4'd4; seq[2] = 4'd2; seq[3] = 4'd5; seq[4] = 4'd3; seq[5] = 4'd0; n = 5;
        end
        for (int i = 0; i < n; i++) begin
            step(1'b1, seq[i], 1'b0, 1'b0);
            step(1'b0, 4'd0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic       nf;
        logic [3:0] exp_sx;

        // reset, then X wins row 0 with 1,4,2,5,3
        add(0,0,0,1, 9'h000,9'h000,0,2'b00,8'h00,0,0,0,0);
        add(1,1,0,0, 9'h001,9'h000,0,2'b00,8'h00,0,0,0,0);
        add(0,0,0,0, 9'h001,9'h000,1,2'b00,8'h00,0,0,0,0);
        add(1,4,0,0, 9'h001,9'h008,1,2'b00,8'h00,0,0,0,0);
        add(0,0,0,0, 9'h001,9'h008,0,2'b00,8'h00,0,0,0,0);
        add(1,2,0,0, 9'h003,9'h008,0,2'b00,8'h00,0,0,0,0);
        add(0,0,0,0, 9'h003,9'h008,1,2'b00,8'h00,0,0,0,0);
        add(1,5,0,0, 9'h003,9'h018,1,2'b00,8'h00,0,0,0,0);
        add(0,0,0,0, 9'h003,9'h018,0,2'b00,8'h00,0,0,0,0);
        add(1,3,0,0, 9'h007,9'h018,0,2'b00,8'h00,0,0,0,0);
        add(0,0,0,0, 9'h007,9'h018,0,2'b01,8'h01,1,0,0,1);
        add(0,0,0,0, 9'h007,9'h018,0,2'b01,8'h01,1,0,0,1);
        add(1,5,0,0, 9'h007,9'h018,0,2'b01,8'h01,1,0,1,1);
        add(0,0,0,0, 9'h007,9'h018,0,2'b01,8'h01,1,0,0,1);
        // new_game: O starts, then X starts again
        add(0,0,1,0, 9'h000,9'h000,1,2'b00,8'h00,1,0,0,0);
        add(0,0,1,0, 9'h000,9'h000,0,2'b00,8'h00,1,0,0,0);
        // occupied cell, bad codes, key during CHECK
        add(1,5,0,0, 9'h010,9'h000,0,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h010,9'h000,1,2'b00,8'h00,1,0,0,0);
        add(1,5,0,0, 9'h010,9'h000,1,2'b00,8'h00,1,0,1,0);
        add(0,0,0,0, 9'h010,9'h000,1,2'b00,8'h00,1,0,0,0);
        add(1,0,0,0, 9'h010,9'h000,1,2'b00,8'h00,1,0,1,0);
        add(0,0,0,0, 9'h010,9'h000,1,2'b00,8'h00,1,0,0,0);
        add(1,12,0,0, 9'h010,9'h000,1,2'b00,8'h00,1,0,1,0);
        add(0,0,0,0, 9'h010,9'h000,1,2'b00,8'h00,1,0,0,0);
        add(1,1,0,0, 9'h010,9'h001,1,2'b00,8'h00,1,0,0,0);
        add(1,2,0,0, 9'h010,9'h001,0,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h010,9'h001,0,2'b00,8'h00,1,0,0,0);
        add(0,0,1,0, 9'h000,9'h000,1,2'b00,8'h00,1,0,0,0);
        add(0,0,1,0, 9'h000,9'h000,0,2'b00,8'h00,1,0,0,0);
        // draw: 5,1,9,3,2,8,7,4,6
        add(1,5,0,0, 9'h010,9'h000,0,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h010,9'h000,1,2'b00,8'h00,1,0,0,0);
        add(1,1,0,0, 9'h010,9'h001,1,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h010,9'h001,0,2'b00,8'h00,1,0,0,0);
        add(1,9,0,0, 9'h110,9'h001,0,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h110,9'h001,1,2'b00,8'h00,1,0,0,0);
        add(1,3,0,0, 9'h110,9'h005,1,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h110,9'h005,0,2'b00,8'h00,1,0,0,0);
        add(1,2,0,0, 9'h112,9'h005,0,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h112,9'h005,1,2'b00,8'h00,1,0,0,0);
        add(1,8,0,0, 9'h112,9'h085,1,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h112,9'h085,0,2'b00,8'h00,1,0,0,0);
        add(1,7,0,0, 9'h152,9'h085,0,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h152,9'h085,1,2'b00,8'h00,1,0,0,0);
        add(1,4,0,0, 9'h152,9'h08D,1,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h152,9'h08D,0,2'b00,8'h00,1,0,0,0);
        add(1,6,0,0, 9'h172,9'h08D,0,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h172,9'h08D,0,2'b11,8'h00,1,0,0,1);
        add(1,1,0,0, 9'h172,9'h08D,0,2'b11,8'h00,1,0,1,1);
        add(0,0,0,0, 9'h172,9'h08D,0,2'b11,8'h00,1,0,0,1);
        add(0,0,1,0, 9'h000,9'h000,1,2'b00,8'h00,1,0,0,0);
        add(0,0,1,0, 9'h000,9'h000,0,2'b00,8'h00,1,0,0,0);
        // win on the 9th move completing both diagonals
        add(1,1,0,0, 9'h001,9'h000,0,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h001,9'h000,1,2'b00,8'h00,1,0,0,0);
        add(1,2,0,0, 9'h001,9'h002,1,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h001,9'h002,0,2'b00,8'h00,1,0,0,0);
        add(1,3,0,0, 9'h005,9'h002,0,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h005,9'h002,1,2'b00,8'h00,1,0,0,0);
        add(1,4,0,0, 9'h005,9'h00A,1,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h005,9'h00A,0,2'b00,8'h00,1,0,0,0);
        add(1,7,0,0, 9'h045,9'h00A,0,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h045,9'h00A,1,2'b00,8'h00,1,0,0,0);
        add(1,6,0,0, 9'h045,9'h02A,1,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h045,9'h02A,0,2'b00,8'h00,1,0,0,0);
        add(1,9,0,0, 9'h145,9'h02A,0,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h145,9'h02A,1,2'b00,8'h00,1,0,0,0);
        add(1,8,0,0, 9'h145,9'h0AA,1,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h145,9'h0AA,0,2'b00,8'h00,1,0,0,0);
        add(1,5,0,0, 9'h155,9'h0AA,0,2'b00,8'h00,1,0,0,0);
        add(0,0,0,0, 9'h155,9'h0AA,0,2'b01,8'hC0,2,0,0,1);
        // new_game beats a same-cycle key
        add(1,5,1,0, 9'h000,9'h000,1,2'b00,8'h00,2,0,0,0);
        add(0,0,0,0, 9'h000,9'h000,1,2'b00,8'h00,2,0,0,0);
        // O wins row 0 with 1,4,2,5,3
        add(1,1,0,0, 9'h000,9'h001,1,2'b00,8'h00,2,0,0,0);
        add(0,0,0,0, 9'h000,9'h001,0,2'b00,8'h00,2,0,0,0);
        add(1,4,0,0, 9'h008,9'h001,0,2'b00,8'h00,2,0,0,0);
        add(0,0,0,0, 9'h008,9'h001,1,2'b00,8'h00,2,0,0,0);
        add(1,2,0,0, 9'h008,9'h003,1,2'b00,8'h00,2,0,0,0);
        add(0,0,0,0, 9'h008,9'h003,0,2'b00,8'h00,2,0,0,0);
        add(1,5,0,0, 9'h018,9'h003,0,2'b00,8'h00,2,0,0,0);
        add(0,0,0,0, 9'h018,9'h003,1,2'b00,8'h00,2,0,0,0);
        add(1,3,0,0, 9'h018,9'h007,1,2'b00,8'h00,2,0,0,0);
        add(0,0,0,0, 9'h018,9'h007,1,2'b10,8'h01,2,1,0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].kv, vecs[i].kc, vecs[i].ng, vecs[i].rs);
            chk($sformatf("row%0d", i), outs(), vecs[i].exp);
        end

        // new_game during CHECK of a winning move: result discarded, score held
        step(0, 0, 1, 0);
        chk("ng_start", outs(), mk(9'h000,9'h000,0,2'b00,8'h00,2,1,0,0));
        step(1,1,0,0); step(0,0,0,0);
        step(1,4,0,0); step(0,0,0,0);
        step(1,2,0,0); step(0,0,0,0);
        step(1,5,0,0); step(0,0,0,0);
        step(1,3,0,0);
        chk("win_pending", outs(), mk(9'h007,9'h018,0,2'b00,8'h00,2,1,0,0));
        step(0, 0, 1, 0);
        chk("ng_in_check", outs(), mk(9'h000,9'h000,1,2'b00,8'h00,2,1,0,0));
        step(0, 0, 0, 0);
        chk("ng_in_check_after", outs(), mk(9'h000,9'h000,1,2'b00,8'h00,2,1,0,0));

        // ten X wins from reset: score saturates at 9
        step(0, 0, 0, 1);
        chk("reset2", outs(), mk(9'h000,9'h000,0,2'b00,8'h00,0,0,0,0));
        nf = 1'b1;
        exp_sx = 4'd0;
        for (int g = 0; g < 10; g++) begin
            step(0, 0, 1, 0);
            chk($sformatf("game%0d_start", g), outs(), mk(9'h000,9'h000,nf,2'b00,8'h00,exp_sx,0,0,0));
            x_win_game(nf);
            nf = ~nf;
            exp_sx = (exp_sx < 4'd9) ? exp_sx + 4'd1 : 4'd9;
            chk4($sformatf("game%0d_score_x", g), score_x, exp_sx);
            chk4($sformatf("game%0d_winner_over", g), {1'b0, winner, game_over}, 4'b0011);
        end

        // reset on the cycle of a winning move: everything returns to reset values
        step(0, 0, 1, 0);
        chk("pre_rst_game", outs(), mk(9'h000,9'h000,1,2'b00,8'h00,9,0,0,0));
        step(1,7,0,0); step(0,0,0,0);
        step(1,1,0,0); step(0,0,0,0);
        step(1,8,0,0); step(0,0,0,0);
        step(1,2,0,0); step(0,0,0,0);
        step(1,4,0,0); step(0,0,0,0);
        chk("pre_rst_board", outs(), mk(9'h003,9'h0C8,0,2'b00,8'h00,9,0,0,0));
        step(1, 3, 0, 1);
        chk("rst_on_win", outs(), mk(9'h000,9'h000,0,2'b00,8'h00,0,0,0,0));
        step(0, 0, 0, 0);
        chk("rst_on_win_after", outs(), mk(9'h000,9'h000,0,2'b00,8'h00,0,0,0,0));
        // next_first was restored by reset: first new_game hands the move to O
        step(0, 0, 1, 0);
        chk("rst_next_first", outs(), mk(9'h000,9'h000,1,2'b00,8'h00,0,0,0,0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
